rol_seq: RTL and testbench
==========================

Name: rol_seq

Overview:
- Sequential rotate-left unit for the ALU shift path. It is the opposite-direction counterpart of the combinational rotate-right.
- Computes c = a rotated left by b, one log-shifter stage per cycle: stage k rotates left by 2^k when b[k]=1.
- Uses a start/done handshake with fixed latency, so the ALU control FSM can issue rotates without a wide combinational path.

Parameters:
- N, 32, datapath width in bits; must be a power of two, N >= 2.
- M, $clog2(N), width of the rotate amount and number of stages.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- start  input  1  request; sampled only when ready=1.
- a  input  N  operand; captured on the accepted start.
- b  input  M  rotate amount; captured on the accepted start.
- ready  output  1  high in IDLE or DONE, meaning a new start is accepted.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse; c is valid from this cycle.
- c  output  N  result; held stable until the next accepted start.

Behaviour:
- Reset (rst_n=0, asynchronous, any state):
  - state=IDLE, stage counter k=0, operand registers cleared.
  - ready=1, busy=0, done=0, c=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - On start=1, capture a into acc and b into amt, set k=0, go to RUN.
  - Otherwise stay in IDLE.
- RUN, each cycle:
  - If amt[k]=1, acc <= {acc[N-1-2^k:0], acc[N-1:N-2^k]}; otherwise acc is unchanged.
  - k <= k+1.
  - When k=M-1, go to DONE and load c with the final acc.
- DONE:
  - done=1 for exactly this one cycle.
  - start=1 here is accepted: capture new operands and go to RUN (back-to-back operation).
  - Otherwise go to IDLE.
- Latency is fixed:
  - start accepted at edge t gives done=1 in the cycle after edge t+M. N=32 gives 5 RUN cycles.
  - Latency is independent of b; b=0 takes the full latency and returns c=a.
- c changes only on the edge that enters DONE, and is held through IDLE.
- start while busy=1 is ignored: no capture, no error, the in-flight operation completes unaffected.
- a and b may change freely after capture without effect on the operation.
- k wraps only via the DONE transition and never exceeds M-1.
- Reset asserted mid-RUN aborts the operation immediately. After release, the unit is in IDLE with c=0 and no done pulse.

Optional Feature:
- Macro ROL_SEQ_CARRY_EN.
- Defined:
  - Adds output port carry (1 bit), registered together with c.
  - carry = final result bit 0 when captured b != 0; otherwise carry holds its previous value (ARM shifter-carry semantics).
  - Reset value 0.
- Undefined:
  - No carry port and no carry logic.
  - All other behaviour identical.

Decomposition:
- Package rol_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} rol_state_t;
  - localparams for the default N/M.
- Sub-module rol_stage:
  - Parameters N and K.
  - Purely combinational: given acc and enable, outputs acc rotated left by 2^K when enable=1, else acc unchanged.
  - rol_seq instantiates M copies via generate and selects the stage output by k, or uses a single variable-stage instance indexed by k.

Test Plan:
- N=32, a=32'h8000_0001, b=1 -> done one cycle after edge t+5, c=32'h0000_0003; with ROL_SEQ_CARRY_EN, carry=1.
- a=32'h1234_5678, b=4 -> c=32'h2345_6781. Then a=32'h0000_0001, b=31 -> c=32'h8000_0000; with ROL_SEQ_CARRY_EN, carry=0.
- a=32'hDEAD_BEEF, b=0 -> c=32'hDEAD_BEEF after the full 5-cycle RUN; carry unchanged.
- Start in the DONE cycle with a=32'h0000_00FF, b=8 -> no IDLE gap, next done exactly 6 cycles later, c=32'h0000_FF00.
  - Also: a start pulse with a=32'hFFFF_FFFF during RUN is ignored and the first result is unaffected.
- Assert rst_n=0 in RUN cycle 3 -> immediately ready=1, busy=0, done=0, c=0.
  - After release, no done pulse without a new start.

Source files
------------

// File: rtl/rol_pkg.sv
// Shared types and default sizing for the sequential rotate-left unit.
package rol_pkg;

  localparam int ROL_N = 32;
  localparam int ROL_M = $clog2(ROL_N);

  typedef enum logic [1:0] {IDLE, RUN, DONE} rol_state_t;

endpackage

// File: rtl/rol_stage.sv
// One log-shifter stage: rotates left by 2^K when en is set, else passes through.
module rol_stage #(
  parameter int N = 32,
  parameter int K = 0
) (
  input  logic [N-1:0] acc_i,
  input  logic         en,
  output logic [N-1:0] acc_o
);

  localparam int S = 1 << K;

  assign acc_o = en ? {acc_i[N-1-S:0], acc_i[N-1:N-S]} : acc_i;

endmodule

// File: rtl/rol_seq.sv
// Sequential rotate-left, one log-shifter stage per cycle, fixed latency.
// Optional macro ROL_SEQ_CARRY_EN adds a registered shifter carry output.
module rol_seq
  import rol_pkg::*;
#(
  parameter int N = ROL_N,
  parameter int M = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [M-1:0] b,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] c
`ifdef ROL_SEQ_CARRY_EN
  ,
  output logic         carry
`endif
);

  // Handshake: a request is accepted on any rising edge where start=1 and
  // ready=1; start is ignored otherwise. done pulses for one cycle and c is
  // valid from that cycle until the next accepted request.

  localparam int unsigned K_LAST = M - 1;

  rol_state_t   state_q, state_d;
  logic [N-1:0] acc_q, acc_d;
  logic [M-1:0] amt_q, amt_d;
  logic [M-1:0] k_q, k_d;
  logic [N-1:0] c_q, c_d;

  logic [N-1:0] stage_out [M];
  logic [N-1:0] stage_sel;

  for (genvar g = 0; g < M; g++) begin : g_stage
    rol_stage #(.N(N), .K(g)) u_stage (
      .acc_i (acc_q),
      .en    (amt_q[g]),
      .acc_o (stage_out[g])
    );
  end

  always_comb begin
    stage_sel = acc_q;
    for (int i = 0; i < M; i++) begin
      if (k_q == i[M-1:0]) stage_sel = stage_out[i];
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    amt_d   = amt_q;
    k_d     = k_q;
    c_d     = c_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          acc_d   = a;
          amt_d   = b;
          k_d     = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d = stage_sel;
        k_d   = k_q + 1'b1;
        if (k_q == K_LAST[M-1:0]) begin
          k_d     = '0;
          c_d     = stage_sel;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      amt_q   <= '0;
      k_q     <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      amt_q   <= amt_d;
      k_q     <= k_d;
      c_q     <= c_d;
    end
  end

  assign ready = (state_q == IDLE) || (state_q == DONE);
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign c     = c_q;

`ifdef ROL_SEQ_CARRY_EN
  logic carry_q, carry_d;

  // A zero rotate leaves the carry untouched, matching ARM shifter semantics.
  always_comb begin
    carry_d = carry_q;
    if (state_q == RUN && k_q == K_LAST[M-1:0] && amt_q != '0) begin
      carry_d = stage_sel[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) carry_q <= 1'b0;
    else        carry_q <= carry_d;
  end

  assign carry = carry_q;
`endif

endmodule

// File: tb/tb_rol_seq.sv
// Directed bench for rol_seq: latency, rotate results, back-to-back, ignored start, async reset.
module tb_rol_seq;

  localparam int N = 32;
  localparam int M = 5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [N-1:0] a;
  logic [M-1:0] b;
  logic         ready;
  logic         busy;
  logic         done;
  logic [N-1:0] c;
`ifdef ROL_SEQ_CARRY_EN
  logic         carry;
`endif

  int chk_cnt = 0;
  int err_cnt = 0;
  logic [N-1:0] exp_q[$];

  rol_seq #(.N(N), .M(M)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .c     (c)
`ifdef ROL_SEQ_CARRY_EN
    ,
    .carry (carry)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver: present a request for one edge, then scramble a/b
  task automatic issue(input logic [N-1:0] av, input logic [M-1:0] bv, input logic [N-1:0] ec);
    exp_q.push_back(ec);
    start = 1'b1;
    a     = av;
    b     = bv;
    step();
    start = 1'b0;
    a     = $urandom;
    b     = M'($urandom_range(0, N - 1));
    check("busy_after_start", {31'b0, busy}, 1);
  endtask

  // scoreboard: bounded wait for done, then compare latency and result
  task automatic wait_done(input int exp_lat, input string tag);
    int lat;
    logic [N-1:0] exp_c;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (done) begin
        lat = i;
        break;
      end
    end
    check({tag, "_lat"}, lat, exp_lat);
    exp_c = exp_q.pop_front();
    check({tag, "_c"}, c, exp_c);
  endtask

  initial begin
    bit seen_done;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #12;
    check("rst_ready", {31'b0, ready}, 1);
    check("rst_busy",  {31'b0, busy},  0);
    check("rst_done",  {31'b0, done},  0);
    check("rst_c",     c,              0);
`ifdef ROL_SEQ_CARRY_EN
    check("rst_carry", {31'b0, carry}, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step();

    issue(32'h8000_0001, 5'd1, 32'h0000_0003);
    wait_done(M, "rol1");
`ifdef ROL_SEQ_CARRY_EN
    check("rol1_carry", {31'b0, carry}, 1);
`endif
    step();
    check("done_one_cycle", {31'b0, done}, 0);
    check("idle_ready", {31'b0, ready}, 1);
    step();
    step();
    check("c_held_idle", c, 32'h0000_0003);

    issue(32'h1234_5678, 5'd4, 32'h2345_6781);
    wait_done(M, "rol4");
    step();

    issue(32'h0000_0001, 5'd31, 32'h8000_0000);
    wait_done(M, "rol31");
`ifdef ROL_SEQ_CARRY_EN
    check("rol31_carry", {31'b0, carry}, 0);
`endif
    step();

    issue(32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF);
    wait_done(M, "rol0");
`ifdef ROL_SEQ_CARRY_EN
    check("rol0_carry_held", {31'b0, carry}, 0);
`endif
    step();

    // first op with an ignored start pulse mid-RUN
    issue(32'h8000_0001, 5'd3, 32'h0000_000C);
    step();
    start = 1'b1;
    a     = 32'hFFFF_FFFF;
    b     = 5'd1;
    step();
    start = 1'b0;
    check("busy_during_run", {31'b0, busy}, 1);
    wait_done(M - 2, "ign");

    // back-to-back start in the DONE cycle
    check("done_ready", {31'b0, ready}, 1);
    begin
      int lat0;
      issue(32'h0000_00FF, 5'd8, 32'h0000_FF00);
      lat0 = 1;
      wait_done(M, "b2b");
      check("b2b_done_to_done", c == 32'h0000_FF00 ? lat0 + M : 0, M + 1);
    end
    step();
    check("b2b_done_pulse", {31'b0, done}, 0);

    // async reset in RUN cycle 3
    start = 1'b1;
    a     = 32'h0F0F_0000;
    b     = 5'd2;
    step();
    start = 1'b0;
    step();
    step();
    check("pre_rst_busy", {31'b0, busy}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", {31'b0, ready}, 1);
    check("mid_rst_busy",  {31'b0, busy},  0);
    check("mid_rst_done",  {31'b0, done},  0);
    check("mid_rst_c",     c,              0);
`ifdef ROL_SEQ_CARRY_EN
    check("mid_rst_carry", {31'b0, carry}, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done) seen_done = 1'b1;
    end
    check("no_done_after_rst", {31'b0, seen_done}, 0);
    check("post_rst_c",     c,              0);
    check("post_rst_ready", {31'b0, ready}, 1);

    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule
